sram_like_arbiter: RTL and testbench
====================================

// Module: sram_like_arbiter
// PURPOSE
//  Shares one sram-like memory port between the fetch (inst) and memory-stage (data) requesters.
//  Sits between the pipeline's inst/data sram-like ports and the single bus bridge to memory.
//  Fixed data-over-inst priority; a streak limit bounds inst starvation.
//  One transaction is outstanding at a time, and every response is routed back to the requester that issued it.
// PARAMETERS
//  STARVE_LIMIT  4  consecutive data grants allowed while inst_req is pending; the next grant then goes to inst.
// PORTS
//  clk           in   1   clock
//  resetn        in   1   reset, synchronous, active-low
//  inst_req      in   1   inst requester: request valid
//  inst_wr       in   1   inst requester: write (normally 0)
//  inst_size     in   2   inst requester: size (0=B, 1=H, 2=W)
//  inst_addr     in   32  inst requester: physical address
//  inst_wdata    in   32  inst requester: write data
//  inst_addr_ok  out  1   inst requester: request accepted
//  inst_data_ok  out  1   inst requester: response valid
//  inst_rdata    out  32  inst requester: read data (= m_rdata)
//  data_req, data_wr, data_size, data_addr, data_wdata  in   same widths as inst_*; data requester
//  data_addr_ok, data_data_ok                           out  1; data requester
//  data_rdata                                           out  32; data requester (= m_rdata)
//  m_req, m_wr, m_size, m_addr, m_wdata                 out  master-side request (1,1,2,32,32)
//  m_addr_ok, m_data_ok                                 in   1; master-side handshake
//  m_rdata                                              in   32; master-side read data
//  arb_busy      out  1   1 when state != IDLE
// BEHAVIOUR
//  State machine
//   - States: IDLE, HOLD, WAIT. Registers: state, owner (0=inst, 1=data), streak counter.
//   - streak width is $clog2(STARVE_LIMIT+1).
//   - Reset: state=IDLE, owner=0, streak=0.
//  Grant in IDLE (combinational)
//   - g = data if data_req && !(inst_req && streak==STARVE_LIMIT).
//   - Otherwise g = inst if inst_req.
//   - Otherwise no grant: m_req=0.
//  Master-side drive
//   - m_* = fields of the granted requester in IDLE, or of owner in HOLD.
//   - m_req = granted requester's req; 0 in WAIT.
//   - m_wr, m_size, m_addr, m_wdata are 0 whenever m_req=0.
//  addr_ok routing
//   - x_addr_ok = m_addr_ok only for the requester currently driving m_*; 0 for the other.
//   - Both are 0 in WAIT.
//  Transitions
//   - IDLE, grant, m_addr_ok=1: latch owner=g, go to WAIT.
//   - IDLE, grant, m_addr_ok=0: latch owner=g, go to HOLD.
//   - HOLD: owner is locked even if the other requester raises req. The owner's fields drive m_*.
//   - HOLD, m_addr_ok=1: go to WAIT.
//   - WAIT, m_data_ok=1: go to IDLE. No same-cycle reissue; the next m_req comes 1 cycle after the response at the earliest.
//  data_ok and rdata routing
//   - owner_data_ok = m_data_ok only in WAIT; the other requester's data_ok = 0.
//   - m_data_ok in IDLE or HOLD is stray: dropped, not forwarded, no state change.
//   - inst_rdata and data_rdata both equal m_rdata; consumers qualify with data_ok.
//  Streak counter
//   - Updated on each accepted request (addr_ok handshake).
//   - Data accepted while inst_req=1: streak++, saturating at STARVE_LIMIT.
//   - Inst accepted: streak=0.
//   - Data accepted while inst_req=0: streak=0.
//  Other rules
//   - Requester dropping req in HOLD is a protocol violation and is not supported. The owner's fields keep driving m_*.
//   - Reset mid-transaction: return to IDLE immediately. A late m_data_ok after reset is dropped as stray.
//   - Zero-latency slave (m_addr_ok and m_data_ok in the same IDLE cycle): m_data_ok is treated as stray, because the response must arrive in WAIT.
// TESTING
//  1. Only inst_req=1 at addr 0x1FC00000, slave addr_ok in the same cycle, data_ok 2 cycles later with rdata 0x24080001
//     -> inst_addr_ok=1 in cycle 0; inst_data_ok=1 and inst_rdata=0x24080001 in cycle 2; data_* outputs stay 0.
//  2. inst_req and data_req both 1 at cycle 0 -> data wins (m_addr=data_addr).
//     After data_ok there is 1 idle cycle, then inst is granted.
//  3. inst_req held, data_req held continuously, STARVE_LIMIT=4
//     -> grant order D,D,D,D,I,D,...; streak returns to 0 after the inst grant.
//  4. Slave addr_ok low 3 cycles; data_req rises during HOLD of an inst grant
//     -> m_addr stays inst_addr for all 3 cycles, data_addr_ok=0, owner=inst.
//  5. Stray m_data_ok=1 in IDLE -> no requester data_ok, state stays IDLE, arb_busy=0.
//  6. resetn=0 while in WAIT -> next cycle state=IDLE, arb_busy=0, streak=0.
//     A slave data_ok arriving afterwards is not forwarded.

Source files
------------

// File: rtl/sram_like_arbiter.sv
// Shares one sram-like master port between the inst (fetch) and data (mem-stage) requesters.
// Data has priority, but a streak limit on consecutive data grants bounds inst starvation.
module sram_like_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        resetn,

  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,

  output logic        m_req,
  output logic        m_wr,
  output logic [1:0]  m_size,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_addr_ok,
  input  logic        m_data_ok,
  input  logic [31:0] m_rdata,

  output logic        arb_busy
);

  localparam int unsigned StreakW = $clog2(STARVE_LIMIT + 1);
  localparam logic [StreakW-1:0] StreakMax = StreakW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    StIdle,
    StHold,
    StWait
  } state_e;

  state_e               state_q, state_d;
  logic                 owner_q, owner_d;   // 0 = inst, 1 = data
  logic [StreakW-1:0]   streak_q, streak_d;

  logic grant_data;
  logic grant_inst;
  logic sel_valid;
  logic sel_data;
  logic accept;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= StIdle;
      owner_q  <= 1'b0;
      streak_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      streak_q <= streak_d;
    end
  end

  always_comb begin
    grant_data = data_req && !(inst_req && (streak_q == StreakMax));
    grant_inst = !grant_data && inst_req;

    state_d   = state_q;
    owner_d   = owner_q;
    streak_d  = streak_q;
    sel_valid = 1'b0;
    sel_data  = 1'b0;

    unique case (state_q)
      StIdle: begin
        sel_valid = grant_data || grant_inst;
        sel_data  = grant_data;
        if (sel_valid) begin
          owner_d = sel_data;
          state_d = m_addr_ok ? StWait : StHold;
        end
      end
      StHold: begin
        // Owner stays locked until the slave accepts, regardless of the other requester.
        sel_valid = 1'b1;
        sel_data  = owner_q;
        if (m_addr_ok) begin
          state_d = StWait;
        end
      end
      StWait: begin
        // Responses outside this state are stray and ignored.
        if (m_data_ok) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    accept = sel_valid && m_addr_ok;

    if (accept) begin
      if (sel_data && inst_req) begin
        streak_d = (streak_q == StreakMax) ? streak_q : streak_q + StreakW'(1);
      end else begin
        streak_d = '0;
      end
    end
  end

  always_comb begin
    m_req   = sel_valid;
    m_wr    = 1'b0;
    m_size  = 2'b00;
    m_addr  = 32'h0;
    m_wdata = 32'h0;
    if (sel_valid) begin
      if (sel_data) begin
        m_wr    = data_wr;
        m_size  = data_size;
        m_addr  = data_addr;
        m_wdata = data_wdata;
      end else begin
        m_wr    = inst_wr;
        m_size  = inst_size;
        m_addr  = inst_addr;
        m_wdata = inst_wdata;
      end
    end
  end

  assign inst_addr_ok = accept && !sel_data;
  assign data_addr_ok = accept && sel_data;

  assign inst_data_ok = (state_q == StWait) && m_data_ok && !owner_q;
  assign data_data_ok = (state_q == StWait) && m_data_ok && owner_q;

  assign inst_rdata = m_rdata;
  assign data_rdata = m_rdata;

  assign arb_busy = (state_q != StIdle);

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Bench for sram_like_arbiter: directed scenarios plus randomized traffic against a
// transaction-level reference model.
module tb_sram_like_arbiter;

  localparam int unsigned Limit = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        m_req, m_wr, m_addr_ok, m_data_ok;
  logic [1:0]  m_size;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic        arb_busy;

  int checks = 0;
  int errors = 0;

  sram_like_arbiter #(.STARVE_LIMIT(Limit)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .inst_req     (inst_req),
    .inst_wr      (inst_wr),
    .inst_size    (inst_size),
    .inst_addr    (inst_addr),
    .inst_wdata   (inst_wdata),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .m_req        (m_req),
    .m_wr         (m_wr),
    .m_size       (m_size),
    .m_addr       (m_addr),
    .m_wdata      (m_wdata),
    .m_addr_ok    (m_addr_ok),
    .m_data_ok    (m_data_ok),
    .m_rdata      (m_rdata),
    .arb_busy     (arb_busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_addr = 0; inst_wdata = 0;
    data_req = 0; data_wr = 0; data_size = 2'd2; data_addr = 0; data_wdata = 0;
    m_addr_ok = 0; m_data_ok = 0; m_rdata = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    resetn = 0;
    step();
    step();
    resetn = 1;
  endtask

  task automatic test_reset();
    do_reset();
    m_data_ok = 1;
    #1;
    checks++;
    if ({arb_busy, m_req, inst_data_ok, data_data_ok} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_idle: busy/m_req/idok/ddok got %b want 0000",
               {arb_busy, m_req, inst_data_ok, data_data_ok});
    end
    checks++;
    if ({m_wr, m_size, m_addr, m_wdata} !== 67'h0) begin
      errors++;
      $display("FAIL reset_m_fields: got %h want 0", {m_wr, m_size, m_addr, m_wdata});
    end
    m_data_ok = 0;
    step();
  endtask

  task automatic test_inst_only();
    do_reset();
    inst_req = 1; inst_addr = 32'h1FC0_0000; m_addr_ok = 1;
    #1;
    checks++;
    if ({inst_addr_ok, data_addr_ok, m_req, m_addr} !== {3'b101, 32'h1FC0_0000}) begin
      errors++;
      $display("FAIL t1_cycle0: iaok/daok/m_req/m_addr got %b %b %b %h want 1 0 1 1fc00000",
               inst_addr_ok, data_addr_ok, m_req, m_addr);
    end
    step();
    inst_req = 0; m_addr_ok = 0;
    #1;
    checks++;
    if ({arb_busy, m_req, inst_data_ok} !== 3'b100) begin
      errors++;
      $display("FAIL t1_cycle1: busy/m_req/idok got %b want 100", {arb_busy, m_req, inst_data_ok});
    end
    step();
    m_data_ok = 1; m_rdata = 32'h2408_0001;
    #1;
    checks++;
    if ({inst_data_ok, inst_rdata, data_data_ok, data_addr_ok} !== {1'b1, 32'h2408_0001, 2'b00})
    begin
      errors++;
      $display("FAIL t1_cycle2: idok/irdata/ddok/daok got %b %h %b %b want 1 24080001 0 0",
               inst_data_ok, inst_rdata, data_data_ok, data_addr_ok);
    end
    step();
    m_data_ok = 0;
    #1;
    checks++;
    if (arb_busy !== 1'b0) begin
      errors++;
      $display("FAIL t1_back_idle: busy got %b want 0", arb_busy);
    end
  endtask

  task automatic test_priority();
    do_reset();
    inst_req = 1; inst_addr = 32'h0000_1000;
    data_req = 1; data_addr = 32'h0000_2000; data_wr = 1; data_wdata = 32'hCAFE_F00D;
    m_addr_ok = 1;
    #1;
    checks++;
    if ({m_addr, m_wr, m_wdata, data_addr_ok, inst_addr_ok} !==
        {32'h0000_2000, 1'b1, 32'hCAFE_F00D, 2'b10}) begin
      errors++;
      $display("FAIL t2_data_wins: m_addr %h wr %b wdata %h daok %b iaok %b want 2000 1 cafef00d 1 0",
               m_addr, m_wr, m_wdata, data_addr_ok, inst_addr_ok);
    end
    step();
    data_req = 0; m_addr_ok = 0; m_data_ok = 1;
    #1;
    checks++;
    if ({data_data_ok, inst_data_ok, m_req} !== 3'b100) begin
      errors++;
      $display("FAIL t2_response: ddok/idok/m_req got %b want 100",
               {data_data_ok, inst_data_ok, m_req});
    end
    step();
    m_data_ok = 0; m_addr_ok = 1;
    #1;
    checks++;
    if ({m_req, m_addr, inst_addr_ok} !== {1'b1, 32'h0000_1000, 1'b1}) begin
      errors++;
      $display("FAIL t2_inst_next: m_req %b m_addr %h iaok %b want 1 00001000 1",
               m_req, m_addr, inst_addr_ok);
    end
    step();
    inst_req = 0; m_addr_ok = 0; m_data_ok = 1;
    step();
    m_data_ok = 0;
  endtask

  task automatic test_starve();
    do_reset();
    inst_req = 1; inst_addr = 32'h0000_1000;
    data_req = 1; data_addr = 32'h0000_2000;
    for (int g = 0; g < 10; g++) begin
      logic [31:0] want;
      want = ((g % (Limit + 1)) == Limit) ? 32'h0000_1000 : 32'h0000_2000;
      m_addr_ok = 1;
      #1;
      checks++;
      if (m_addr !== want) begin
        errors++;
        $display("FAIL t3_grant_%0d: m_addr got %h want %h", g, m_addr, want);
      end
      step();
      m_addr_ok = 0; m_data_ok = 1;
      step();
      m_data_ok = 0;
    end
    clear_inputs();
  endtask

  task automatic test_hold();
    do_reset();
    inst_req = 1; inst_addr = 32'h0000_3000;
    data_addr = 32'h0000_4000;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) data_req = 1;
      #1;
      checks++;
      if ({m_req, m_addr, data_addr_ok, inst_addr_ok} !== {1'b1, 32'h0000_3000, 2'b00}) begin
        errors++;
        $display("FAIL t4_hold_%0d: m_req %b m_addr %h daok %b iaok %b want 1 00003000 0 0",
                 c, m_req, m_addr, data_addr_ok, inst_addr_ok);
      end
      step();
    end
    m_addr_ok = 1;
    #1;
    checks++;
    if ({m_addr, inst_addr_ok, data_addr_ok} !== {32'h0000_3000, 2'b10}) begin
      errors++;
      $display("FAIL t4_accept: m_addr %h iaok %b daok %b want 00003000 1 0",
               m_addr, inst_addr_ok, data_addr_ok);
    end
    step();
    inst_req = 0; m_addr_ok = 0; m_data_ok = 1;
    #1;
    checks++;
    if ({inst_data_ok, data_data_ok} !== 2'b10) begin
      errors++;
      $display("FAIL t4_owner_inst: idok/ddok got %b want 10", {inst_data_ok, data_data_ok});
    end
    step();
    clear_inputs();
  endtask

  task automatic test_stray();
    do_reset();
    m_data_ok = 1;
    #1;
    checks++;
    if ({inst_data_ok, data_data_ok, arb_busy} !== 3'b000) begin
      errors++;
      $display("FAIL t5_stray: idok/ddok/busy got %b want 000",
               {inst_data_ok, data_data_ok, arb_busy});
    end
    step();
    m_data_ok = 0;
    #1;
    checks++;
    if (arb_busy !== 1'b0) begin
      errors++;
      $display("FAIL t5_still_idle: busy got %b want 0", arb_busy);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    inst_req = 1; inst_addr = 32'h0000_1000;
    data_req = 1; data_addr = 32'h0000_2000;
    // Three full data transactions, then a fourth left outstanding with streak at the limit.
    for (int g = 0; g < Limit; g++) begin
      m_addr_ok = 1;
      step();
      m_addr_ok = 0;
      if (g < Limit - 1) begin
        m_data_ok = 1;
        step();
        m_data_ok = 0;
      end
    end
    resetn = 0;
    step();
    resetn = 1; inst_req = 0; data_req = 0;
    #1;
    checks++;
    if (arb_busy !== 1'b0) begin
      errors++;
      $display("FAIL t6_idle_after_reset: busy got %b want 0", arb_busy);
    end
    m_data_ok = 1;
    #1;
    checks++;
    if ({inst_data_ok, data_data_ok, arb_busy} !== 3'b000) begin
      errors++;
      $display("FAIL t6_late_response: idok/ddok/busy got %b want 000",
               {inst_data_ok, data_data_ok, arb_busy});
    end
    step();
    m_data_ok = 0; inst_req = 1; data_req = 1; m_addr_ok = 1;
    #1;
    checks++;
    if (m_addr !== 32'h0000_2000) begin
      errors++;
      $display("FAIL t6_streak_cleared: m_addr got %h want 00002000", m_addr);
    end
    step();
    clear_inputs();
    m_data_ok = 1;
    step();
    m_data_ok = 0;
  endtask

  // Reference model: phase 0 = no transaction, 1 = granted awaiting accept, 2 = awaiting response.
  task automatic test_random();
    int phase, owner, streak;
    bit ipend, dpend;
    bit req, sel;
    logic [136:0] got, want;
    do_reset();
    phase = 0; owner = 0; streak = 0; ipend = 0; dpend = 0;
    for (int c = 0; c < 400; c++) begin
      if (!ipend && $urandom_range(0, 2) == 0) begin
        ipend = 1; inst_addr = $urandom; inst_wdata = $urandom;
        inst_wr = 1'($urandom_range(0, 1)); inst_size = 2'($urandom_range(0, 2));
      end
      if (!dpend && $urandom_range(0, 1) == 0) begin
        dpend = 1; data_addr = $urandom; data_wdata = $urandom;
        data_wr = 1'($urandom_range(0, 1)); data_size = 2'($urandom_range(0, 2));
      end
      inst_req = ipend; data_req = dpend;
      m_addr_ok = 1'($urandom_range(0, 1));
      m_data_ok = 1'($urandom_range(0, 2) != 0);
      m_rdata = $urandom;
      #1;
      if (phase == 0) begin
        sel = dpend && !(ipend && streak == Limit);
        req = sel || ipend;
      end else if (phase == 1) begin
        req = 1; sel = (owner == 1);
      end else begin
        req = 0; sel = 0;
      end
      want = {req,
              req ? (sel ? {data_wr, data_size, data_addr, data_wdata}
                         : {inst_wr, inst_size, inst_addr, inst_wdata}) : 67'h0,
              req && !sel && m_addr_ok, req && sel && m_addr_ok,
              phase == 2 && m_data_ok && owner == 0, phase == 2 && m_data_ok && owner == 1,
              phase != 0, m_rdata, m_rdata};
      got = {m_req, m_wr, m_size, m_addr, m_wdata, inst_addr_ok, data_addr_ok,
             inst_data_ok, data_data_ok, arb_busy, inst_rdata, data_rdata};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL rand_cycle_%0d: outputs got %h want %h", c, got, want);
      end
      if (req && m_addr_ok) begin
        if (sel) begin
          streak = ipend ? ((streak < Limit) ? streak + 1 : Limit) : 0;
          dpend = 0;
        end else begin
          streak = 0;
          ipend = 0;
        end
      end
      if (phase == 0 && req) begin
        owner = sel ? 1 : 0;
        phase = m_addr_ok ? 2 : 1;
      end else if (phase == 1 && m_addr_ok) begin
        phase = 2;
      end else if (phase == 2 && m_data_ok) begin
        phase = 0;
      end
      step();
    end
    clear_inputs();
  endtask

  initial begin
    resetn = 0;
    clear_inputs();
    test_reset();
    test_inst_only();
    test_priority();
    test_starve();
    test_hold();
    test_stray();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
